// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite blitter.
//   rgb12_t      : packed {r[3:0], g[3:0], b[3:0]} colour
//   SCREEN_W/H   : visible raster size
//   box_span_hit : clipped 11-bit span test, coord in [origin, origin+span)
package sprite_pkg;

    typedef logic [11:0] rgb12_t;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    // The end is computed one bit wider so a box running off the raster never wraps to 0.
    function automatic logic box_span_hit(input logic [10:0] coord,
                                          input logic [10:0] origin,
                                          input logic [10:0] span);
        logic [11:0] w_end;
        w_end = {1'b0, origin} + {1'b0, span};
        return (coord >= origin) && ({1'b0, coord} < w_end);
    endfunction

endpackage

// File: rtl/sprite_anim_seq.sv
// Animation sequencer: divides frame_tick pulses by FRAME_TICKS and steps a
// wrapping frame counter.
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_anim_en       : enable counting (0 freezes both counters)
//   i_restart       : force tick and frame counters to 0 (highest priority)
//   i_frame_tick    : one-cycle pulse per video frame
//   o_frame         : current animation frame
module sprite_anim_seq #(
    parameter int unsigned N_FRAMES    = 4,
    parameter int unsigned FRAME_TICKS = 8,
    localparam int unsigned FRAME_W    = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1,
    localparam int unsigned TICK_W     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_anim_en,
    input  logic               i_restart,
    input  logic               i_frame_tick,
    output logic [FRAME_W-1:0] o_frame
);

    logic [TICK_W-1:0]  r_tick;
    logic [TICK_W-1:0]  w_tick_nxt;
    logic [FRAME_W-1:0] r_frame;
    logic [FRAME_W-1:0] w_frame_nxt;

    always_comb begin
        w_tick_nxt  = r_tick;
        w_frame_nxt = r_frame;
        if (i_restart) begin
            w_tick_nxt  = '0;
            w_frame_nxt = '0;
        end else if (i_frame_tick && i_anim_en) begin
            if (r_tick == TICK_W'(FRAME_TICKS - 1)) begin
                w_tick_nxt  = '0;
                // With N_FRAMES == 1 the compare is always true, pinning the frame at 0.
                w_frame_nxt = (r_frame == FRAME_W'(N_FRAMES - 1)) ? '0
                                                                  : r_frame + FRAME_W'(1);
            end else begin
                w_tick_nxt = r_tick + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick  <= '0;
            r_frame <= '0;
        end else begin
            r_tick  <= w_tick_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    assign o_frame = r_frame;

endmodule

// File: rtl/sprite_blitter.sv
// Positioned, scaled, flippable, animated sprite renderer composited over a
// background colour. Fixed 3-cycle latency from DrawX/DrawY to RGB.
//   vga_clk, reset_n        : pixel clock, asynchronous active-low reset
//   DrawX, DrawY, blank     : raster position, 1 = active video
//   bg_rgb                  : background colour aligned with DrawX
//   pos_x, pos_y, flip_h    : sprite placement and horizontal mirror
//   anim_en, anim_restart,
//   frame_tick              : animation control
//   rom_address / rom_q     : external sprite ROM (1-cycle read latency)
//   pal_index / pal_rgb     : external combinational palette
//   red, green, blue, hit   : registered pixel output, opaque-sprite flag
//   cur_frame               : current animation frame
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int unsigned SPR_W           = 32,
    parameter int unsigned SPR_H           = 32,
    parameter int unsigned SCALE_LOG2      = 1,
    parameter int unsigned N_FRAMES        = 4,
    parameter int unsigned IDX_BITS        = 3,
    parameter int unsigned TRANSPARENT_IDX = 0,
    parameter int unsigned FRAME_TICKS     = 8,
    localparam int unsigned ADDR_W         = $clog2(SPR_W * SPR_H * N_FRAMES),
    localparam int unsigned FRAME_W        = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic                blank,
    input  logic [11:0]         bg_rgb,
    input  logic [9:0]          pos_x,
    input  logic [9:0]          pos_y,
    input  logic                flip_h,
    input  logic                anim_en,
    input  logic                anim_restart,
    input  logic                frame_tick,
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [IDX_BITS-1:0] rom_q,
    output logic [IDX_BITS-1:0] pal_index,
    input  logic [11:0]         pal_rgb,
    output logic [3:0]          red,
    output logic [3:0]          green,
    output logic [3:0]          blue,
    output logic                hit,
    output logic [FRAME_W-1:0]  cur_frame
);

    localparam int unsigned TX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned TY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    localparam logic [10:0]       BOX_W    = 11'(SPR_W << SCALE_LOG2);
    localparam logic [10:0]       BOX_H    = 11'(SPR_H << SCALE_LOG2);
    localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);
    localparam logic [ADDR_W-1:0] ROW_SZ   = ADDR_W'(SPR_W);

    // Animation sequencer
    sprite_anim_seq #(
        .N_FRAMES    (N_FRAMES),
        .FRAME_TICKS (FRAME_TICKS)
    ) u_anim_seq (
        .i_clk        (vga_clk),
        .i_rst_n      (reset_n),
        .i_anim_en    (anim_en),
        .i_restart    (anim_restart),
        .i_frame_tick (frame_tick),
        .o_frame      (cur_frame)
    );

    // Stage 0: box test and texel coordinates
    logic [10:0]     w_dx, w_dy, w_px, w_py;
    logic [10:0]     w_offx, w_offy;
    logic            w_inbox;
    logic [TX_W-1:0] w_tx_raw, w_tx;
    logic [TY_W-1:0] w_ty;

    assign w_dx    = {1'b0, DrawX};
    assign w_dy    = {1'b0, DrawY};
    assign w_px    = {1'b0, pos_x};
    assign w_py    = {1'b0, pos_y};
    assign w_inbox = box_span_hit(w_dx, w_px, BOX_W) && box_span_hit(w_dy, w_py, BOX_H);

    // Offsets are only meaningful inside the box; outside, the address is forced to 0.
    assign w_offx   = w_dx - w_px;
    assign w_offy   = w_dy - w_py;
    assign w_tx_raw = TX_W'(w_offx >> SCALE_LOG2);
    assign w_ty     = TY_W'(w_offy >> SCALE_LOG2);
    assign w_tx     = flip_h ? (TX_W'(SPR_W - 1) - w_tx_raw) : w_tx_raw;

    // Stage 1 registers (edge 1)
    logic               r1_inbox, r1_blank;
    rgb12_t             r1_bg;
    logic [TX_W-1:0]    r1_tx;
    logic [TY_W-1:0]    r1_ty;
    logic [FRAME_W-1:0] r1_frame;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r1_inbox <= 1'b0;
            r1_blank <= 1'b0;
            r1_bg    <= '0;
            r1_tx    <= '0;
            r1_ty    <= '0;
            r1_frame <= '0;
        end else begin
            r1_inbox <= w_inbox;
            r1_blank <= blank;
            r1_bg    <= bg_rgb;
            r1_tx    <= w_tx;
            r1_ty    <= w_ty;
            r1_frame <= cur_frame;
        end
    end

    logic [ADDR_W-1:0] w_addr;

    assign w_addr      = ADDR_W'(r1_frame) * FRAME_SZ + ADDR_W'(r1_ty) * ROW_SZ
                       + ADDR_W'(r1_tx);
    assign rom_address = r1_inbox ? w_addr : '0;

    // Stage 2 registers (edge 2, alongside the ROM read)
    logic   r2_inbox, r2_blank;
    rgb12_t r2_bg;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r2_inbox <= 1'b0;
            r2_blank <= 1'b0;
            r2_bg    <= '0;
        end else begin
            r2_inbox <= r1_inbox;
            r2_blank <= r1_blank;
            r2_bg    <= r1_bg;
        end
    end

    assign pal_index = rom_q;

    // Output compositing (edge 3)
    logic   w_opaque;
    rgb12_t r_rgb;
    logic   r_hit;

    assign w_opaque = r2_inbox && (rom_q != IDX_BITS'(TRANSPARENT_IDX));

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb <= '0;
            r_hit <= 1'b0;
        end else if (!r2_blank) begin
            r_rgb <= '0;
            r_hit <= 1'b0;
        end else if (w_opaque) begin
            r_rgb <= pal_rgb;
            r_hit <= 1'b1;
        end else begin
            r_rgb <= r2_bg;
            r_hit <= 1'b0;
        end
    end

    assign red   = r_rgb[11:8];
    assign green = r_rgb[7:4];
    assign blue  = r_rgb[3:0];
    assign hit   = r_hit;

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Parametrised, positioned, animated sprite renderer for the VGA pixel pipeline.
- Maps DrawX/DrawY onto a movable sprite box with integer scale, horizontal flip, a multi-frame animation sequencer and a transparent palette index.
- Drives an external clocked sprite ROM and combinational palette.
- Composites the sprite over a background colour, emitting registered 4-bit RGB with fixed 3-cycle latency.

Parameters:
- SPR_W, 32, sprite width in texels (power of two).
- SPR_H, 32, sprite height in texels.
- SCALE_LOG2, 1, screen pixels per texel = 2^SCALE_LOG2 in each axis.
- N_FRAMES, 4, animation frames stored back-to-back in the ROM.
- IDX_BITS, 3, palette index width.
- TRANSPARENT_IDX, 0, index drawn as background.
- FRAME_TICKS, 8, frame_tick pulses per animation step (≥1).
- ADDR_W, clog2(SPR_W*SPR_H*N_FRAMES), ROM address width (localparam).

Ports:
- vga_clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- bg_rgb  in  12  background colour {r,g,b}, aligned with DrawX.
- pos_x  in  10  sprite top-left column.
- pos_y  in  10  sprite top-left row.
- flip_h  in  1  mirror horizontally.
- anim_en  in  1  enable frame advance.
- anim_restart  in  1  force frame 0.
- frame_tick  in  1  one-cycle pulse per video frame.
- rom_address  out  ADDR_W  to sprite ROM (1-cycle read latency).
- rom_q  in  IDX_BITS  ROM data.
- pal_index  out  IDX_BITS  to palette (combinational from rom_q).
- pal_rgb  in  12  palette colour.
- red  out  4  pixel red.
- green  out  4  pixel green.
- blue  out  4  pixel blue.
- hit  out  1  opaque sprite pixel at this output.
- cur_frame  out  clog2(N_FRAMES)  current animation frame.

Behaviour:
- Reset (async, reset_n=0): red/green/blue=0, hit=0, cur_frame=0, tick counter=0, all pipeline valid/inbox bits=0. Release is synchronous to the next vga_clk edge.
- Box test, 11-bit unsigned arithmetic with no wrap:
  - inbox = DrawX≥pos_x && DrawX<pos_x+(SPR_W<<SCALE_LOG2) && DrawY≥pos_y && DrawY<pos_y+(SPR_H<<SCALE_LOG2).
  - A box extending past 639/479 is clipped naturally.
- Texel: tx=(DrawX−pos_x)>>SCALE_LOG2, ty=(DrawY−pos_y)>>SCALE_LOG2; if flip_h, tx=SPR_W−1−tx.
- Address = cur_frame*SPR_W*SPR_H + ty*SPR_W + tx. When !inbox, address is don't-care but must stay in range (drive 0).
- Pipeline:
  - Edge 1 registers inbox, blank, bg_rgb, tx, ty and frame; rom_address is driven from these registers.
  - Edge 2: ROM captures; inbox/blank/bg delayed to stage 2; pal_index=rom_q.
  - Edge 3 registers the output.
  - Total latency DrawX→RGB = 3 cycles, constant, with no bubbles.
- Output mux at edge 3:
  - !blank → RGB 0, hit 0.
  - else inbox && rom_q≠TRANSPARENT_IDX → pal_rgb, hit 1.
  - else → bg_rgb, hit 0.
- Animation sequencer, in priority order:
  - anim_restart → tick_cnt=0, cur_frame=0 (regardless of frame_tick/anim_en).
  - else frame_tick && anim_en → if tick_cnt==FRAME_TICKS−1 then tick_cnt=0 and cur_frame = (cur_frame==N_FRAMES−1) ? 0 : cur_frame+1; else tick_cnt+1.
  - else hold. anim_en=0 freezes both counters.
- cur_frame changes only on frame_tick or anim_restart, so a frame is never torn when frame_tick is asserted in vertical blank.
- pos_x, pos_y and flip_h are sampled every pixel at edge 1; they are not latched per frame (the caller updates them in blank).
- N_FRAMES=1: cur_frame is constant 0; tick_cnt still counts.

Decomposition:
- Package sprite_pkg: RGB12 typedef, SCREEN_W=640, SCREEN_H=480, and a helper function for the clipped 11-bit box compare.
- One natural sub-module: sprite_anim_seq (tick counter plus frame counter with restart), instantiated once.
- ROM and palette remain external per-asset modules.

Test Plan:
- Reset mid-frame: assert reset_n=0 with blank=1 and the sprite visible → RGB=0, hit=0, cur_frame=0 immediately (asynchronous).
- Placement: pos=(100,50), SCALE_LOG2=1, ROM texel(0,0)=5 → DrawX=100..101, DrawY=50 gives pal_rgb and hit=1 three cycles later. DrawX=99 and DrawX=164 give bg_rgb with hit=0.
- Flip: flip_h=1 at DrawX=100, DrawY=50 → rom_address=31. With flip_h=0 → rom_address=0.
- Transparency and blank:
  - rom_q=TRANSPARENT_IDX inside the box → bg_rgb, hit=0.
  - blank=0 anywhere → 0x000.
- Animation: anim_en=1, FRAME_TICKS=8, N_FRAMES=4.
  - 8 frame_ticks → cur_frame=1; 32 ticks → wraps to 0.
  - anim_restart coincident with frame_tick at tick 7 → frame 0, tick 0.
  - anim_en=0 holds.
- Right-edge clip: pos_x=620 → pixels 620..639 drawn; no wrap to column 0; rom_address stays < SPR_W*SPR_H*N_FRAMES.
